// File: rtl/ma_amo_unit_if.sv
// Data-memory port shared between the AMO sequencer (master) and the
// single-ported data memory (slave).
interface ma_amo_unit_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] o_mem_addr;
    logic [XLEN-1:0] o_mem_wdata;
    logic [3:0]      o_mem_byte_we;
    logic            o_mem_own;
    logic [XLEN-1:0] i_mem_rdata;

    modport master (
        output o_mem_addr,
        output o_mem_wdata,
        output o_mem_byte_we,
        output o_mem_own,
        input  i_mem_rdata
    );

    modport slave (
        input  o_mem_addr,
        input  o_mem_wdata,
        input  o_mem_byte_we,
        input  o_mem_own,
        output i_mem_rdata
    );
endinterface

// File: rtl/ma_amo_unit.sv
// ma_amo_unit: memory-stage sequencer that performs the read-modify-write of
// RV32A word AMOs on the data memory and owns the LR/SC reservation register.
// The memory returns read data one cycle after the address, so the address is
// driven straight from the pipeline in the start cycle and everything after
// that comes from registers.
module ma_amo_unit #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_amo_valid,
    input  logic [4:0]      i_amo_funct5,
    input  logic [XLEN-1:0] i_address,
    input  logic [XLEN-1:0] i_rs2_value,
    input  logic            i_lr_valid,
    input  logic            i_sc_valid,
    input  logic            i_store_valid,
    input  logic            i_trap,
    input  logic            i_stall,
    ma_amo_unit_if.master   mem,
    output logic            o_stall,
    output logic            o_result_valid,
    output logic [XLEN-1:0] o_result,
    output logic            o_reservation_valid,
    output logic [XLEN-3:0] o_reservation_addr
);

    localparam logic [4:0] F5_ADD  = 5'b00000;
    localparam logic [4:0] F5_SWAP = 5'b00001;
    localparam logic [4:0] F5_XOR  = 5'b00100;
    localparam logic [4:0] F5_OR   = 5'b01000;
    localparam logic [4:0] F5_AND  = 5'b01100;
    localparam logic [4:0] F5_MIN  = 5'b10000;
    localparam logic [4:0] F5_MAX  = 5'b10100;
    localparam logic [4:0] F5_MINU = 5'b11000;
    localparam logic [4:0] F5_MAXU = 5'b11100;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t          state;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] rs2_q;
    logic [4:0]      funct5_q;
    logic [XLEN-1:0] wdata_q;
    logic [3:0]      byte_we_q;
    logic            own_q;
    logic            stall_q;
    logic            idle_start;
    logic [XLEN-1:0] old_data;
    logic [XLEN-1:0] amo_new;

    // An AMO arriving in IDLE must stall the pipe and put its address on the
    // memory port in that same cycle; later cycles use registered values.
    assign idle_start = (state == IDLE) && i_amo_valid && !i_rst;
    assign old_data   = mem.i_mem_rdata;

    assign o_stall           = stall_q | idle_start;
    assign mem.o_mem_own     = own_q | idle_start;
    assign mem.o_mem_addr    = idle_start ? i_address : addr_q;
    assign mem.o_mem_wdata   = wdata_q;
    assign mem.o_mem_byte_we = byte_we_q;

    // Modify step: new memory word from the old word and rs2; unknown funct5
    // values write the old word back unchanged.
    always_comb begin
        amo_new = old_data;
        case (funct5_q)
            F5_SWAP: amo_new = rs2_q;
            F5_ADD:  amo_new = old_data + rs2_q;
            F5_XOR:  amo_new = old_data ^ rs2_q;
            F5_AND:  amo_new = old_data & rs2_q;
            F5_OR:   amo_new = old_data | rs2_q;
            F5_MIN:  amo_new = ($signed(old_data) < $signed(rs2_q)) ? old_data : rs2_q;
            F5_MAX:  amo_new = ($signed(old_data) > $signed(rs2_q)) ? old_data : rs2_q;
            F5_MINU: amo_new = (old_data < rs2_q) ? old_data : rs2_q;
            F5_MAXU: amo_new = (old_data > rs2_q) ? old_data : rs2_q;
            default: amo_new = old_data;
        endcase
    end

    // Sequencer: IDLE issues the read, READ captures old data and computes the
    // new word, WRITE stores it, DONE presents the old word until the pipe moves.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= IDLE;
            addr_q         <= '0;
            rs2_q          <= '0;
            funct5_q       <= '0;
            wdata_q        <= '0;
            byte_we_q      <= 4'h0;
            own_q          <= 1'b0;
            stall_q        <= 1'b0;
            o_result_valid <= 1'b0;
            o_result       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    byte_we_q      <= 4'h0;
                    o_result_valid <= 1'b0;
                    if (i_amo_valid) begin
                        addr_q   <= i_address;
                        rs2_q    <= i_rs2_value;
                        funct5_q <= i_amo_funct5;
                        own_q    <= 1'b1;
                        stall_q  <= 1'b1;
                        state    <= READ;
                    end else begin
                        own_q   <= 1'b0;
                        stall_q <= 1'b0;
                    end
                end
                READ: begin
                    o_result  <= old_data;
                    wdata_q   <= amo_new;
                    byte_we_q <= 4'hF;
                    own_q     <= 1'b1;
                    stall_q   <= 1'b1;
                    state     <= WRITE;
                end
                WRITE: begin
                    byte_we_q      <= 4'h0;
                    own_q          <= 1'b0;
                    stall_q        <= 1'b0;
                    o_result_valid <= 1'b1;
                    state          <= DONE;
                end
                DONE: begin
                    if (!i_stall) begin
                        o_result_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: begin
                    byte_we_q      <= 4'h0;
                    own_q          <= 1'b0;
                    stall_q        <= 1'b0;
                    o_result_valid <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

    // Reservation register: an AMO write to the reserved word always kills it;
    // otherwise only instructions that actually advance may change it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_reservation_valid <= 1'b0;
            o_reservation_addr  <= '0;
        end else if ((state == WRITE) && (addr_q[XLEN-1:2] == o_reservation_addr)) begin
            o_reservation_valid <= 1'b0;
        end else if (!i_stall && !o_stall) begin
            if (i_trap) begin
                o_reservation_valid <= 1'b0;
            end else if (i_sc_valid) begin
                o_reservation_valid <= 1'b0;
            end else if (i_lr_valid) begin
                o_reservation_valid <= 1'b1;
                o_reservation_addr  <= i_address[XLEN-1:2];
            end else if (i_store_valid && (i_address[XLEN-1:2] == o_reservation_addr)) begin
                o_reservation_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ma_amo_unit.sv
// Testbench for ma_amo_unit: directed scenarios plus randomized AMO / LR / SC /
// store / trap traffic, checked against a word-level memory and reservation
// model through a scoreboard of expected results and memory writes.
module tb_ma_amo_unit;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        amo_valid;
    logic [4:0]  amo_funct5;
    logic [31:0] address;
    logic [31:0] rs2_value;
    logic        lr_valid;
    logic        sc_valid;
    logic        store_valid;
    logic        trap;
    logic        stall_in;
    logic        o_stall;
    logic        o_result_valid;
    logic [31:0] o_result;
    logic        o_reservation_valid;
    logic [29:0] o_reservation_addr;

    ma_amo_unit_if #(.XLEN(XLEN)) mem_if ();

    ma_amo_unit #(.XLEN(XLEN)) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_amo_valid         (amo_valid),
        .i_amo_funct5        (amo_funct5),
        .i_address           (address),
        .i_rs2_value         (rs2_value),
        .i_lr_valid          (lr_valid),
        .i_sc_valid          (sc_valid),
        .i_store_valid       (store_valid),
        .i_trap              (trap),
        .i_stall             (stall_in),
        .mem                 (mem_if),
        .o_stall             (o_stall),
        .o_result_valid      (o_result_valid),
        .o_result            (o_result),
        .o_reservation_valid (o_reservation_valid),
        .o_reservation_addr  (o_reservation_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] old;
        int          dur;
    } res_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_exp_t;

    int          tests = 0;
    int          failures = 0;
    int          writes_seen = 0;
    int          writes_expected = 0;
    res_exp_t    exp_res_q[$];
    wr_exp_t     exp_wr_q[$];
    logic [31:0] mem [0:255];
    logic [31:0] ref_mem [0:255];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_idx = 8'd0;
    logic [31:0] pre_data = 32'd0;
    logic        res_v = 1'b0;
    logic [29:0] res_a = 30'd0;
    logic        rv_prev = 1'b0;
    int          rv_len = 0;
    int          dur_exp = 0;

    // Single-ported data memory with one-cycle read latency
    always @(posedge clk) begin
        mem_if.i_mem_rdata <= mem[mem_if.o_mem_addr[9:2]];
        if (pre_we) begin
            mem[pre_idx] <= pre_data;
        end else if (mem_if.o_mem_own) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_if.o_mem_byte_we[b]) mem[mem_if.o_mem_addr[9:2]][8*b +: 8] <= mem_if.o_mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] refAmo(input logic [4:0] f5, input logic [31:0] old, input logic [31:0] rs2);
        int signed so;
        int signed sr;
        so = old;
        sr = rs2;
        case (f5)
            5'd1:    return rs2;
            5'd0:    return old + rs2;
            5'd4:    return old ^ rs2;
            5'd12:   return old & rs2;
            5'd8:    return old | rs2;
            5'd16:   return (so < sr) ? old : rs2;
            5'd20:   return (so > sr) ? old : rs2;
            5'd24:   return (old < rs2) ? old : rs2;
            5'd28:   return (old > rs2) ? old : rs2;
            default: return old;
        endcase
    endfunction

    task automatic checkReservation(input string name);
        checkOutput({name, "_valid"}, {31'd0, o_reservation_valid}, {31'd0, res_v});
        if (res_v) checkOutput({name, "_addr"}, {2'b00, o_reservation_addr}, {2'b00, res_a});
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        pre_we = 1'b1;
        pre_idx = idx;
        pre_data = data;
        ref_mem[idx] = data;
        @(posedge clk);
        #1;
        pre_we = 1'b0;
    endtask

    // Issue one AMO, expect 3 stall cycles, optionally hold DONE with i_stall
    task automatic applyStimulus(input logic [4:0] f5, input logic [31:0] addr, input logic [31:0] rs2, input int hold);
        logic [31:0] old_v;
        logic [31:0] new_v;
        int          n;
        res_exp_t    re;
        wr_exp_t     we_e;
        old_v = ref_mem[addr[9:2]];
        new_v = refAmo(f5, old_v, rs2);
        ref_mem[addr[9:2]] = new_v;
        re.old = old_v;
        re.dur = hold + 1;
        exp_res_q.push_back(re);
        we_e.addr = addr;
        we_e.data = new_v;
        exp_wr_q.push_back(we_e);
        writes_expected++;
        if (res_v && addr[31:2] == res_a) res_v = 1'b0;
        amo_valid = 1'b1;
        amo_funct5 = f5;
        address = addr;
        rs2_value = rs2;
        n = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (!o_stall) break;
            n++;
        end
        checkOutput("stall_cycles", n, 32'd3);
        if (hold > 0) begin
            stall_in = 1'b1;
            repeat (hold) @(posedge clk);
            #1;
            stall_in = 1'b0;
        end
        @(posedge clk);
        #1;
        amo_valid = 1'b0;
        checkReservation("amo_res");
    endtask

    // One pipeline cycle of LR / SC / store / trap with the reservation model
    task automatic applyPipe(input logic lr, input logic sc, input logic st, input logic tr, input logic [31:0] addr);
        if (tr) res_v = 1'b0;
        else if (sc) res_v = 1'b0;
        else if (lr) begin
            res_v = 1'b1;
            res_a = addr[31:2];
        end else if (st && addr[31:2] == res_a) res_v = 1'b0;
        lr_valid = lr;
        sc_valid = sc;
        store_valid = st;
        trap = tr;
        address = addr;
        @(posedge clk);
        #1;
        lr_valid = 1'b0;
        sc_valid = 1'b0;
        store_valid = 1'b0;
        trap = 1'b0;
        checkReservation("pipe_res");
    endtask

    // Scoreboard monitor: memory writes and result pulses
    initial begin
        res_exp_t re;
        wr_exp_t  we_e;
        forever begin
            @(negedge clk);
            if (mem_if.o_mem_byte_we != 4'h0) begin
                writes_seen++;
                if (exp_wr_q.size() == 0) begin
                    tests++;
                    failures++;
                    $display("[TB] FAIL unexpected_write: got addr %h data %h, expected no write", mem_if.o_mem_addr, mem_if.o_mem_wdata);
                end else begin
                    we_e = exp_wr_q.pop_front();
                    checkOutput("write_addr", mem_if.o_mem_addr, we_e.addr);
                    checkOutput("write_data", mem_if.o_mem_wdata, we_e.data);
                    checkOutput("write_we", {28'd0, mem_if.o_mem_byte_we}, 32'hF);
                end
            end
            if (o_result_valid) begin
                checkOutput("done_mem_own", {31'd0, mem_if.o_mem_own}, 32'd0);
                if (!rv_prev) begin
                    rv_len = 1;
                    if (exp_res_q.size() == 0) begin
                        tests++;
                        failures++;
                        dur_exp = 0;
                        $display("[TB] FAIL unexpected_result: got %h, expected no result", o_result);
                    end else begin
                        re = exp_res_q.pop_front();
                        dur_exp = re.dur;
                        checkOutput("result", o_result, re.old);
                    end
                end else begin
                    rv_len++;
                end
            end else if (rv_prev) begin
                checkOutput("result_valid_cycles", rv_len, dur_exp);
            end
            rv_prev = o_result_valid;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL timeout: got no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int          wbefore;
        int          mism;
        int          op;
        logic [31:0] a;
        logic [31:0] addr_pool [0:3];
        logic [4:0]  f5_pool [0:9];
        addr_pool[0] = 32'h200; addr_pool[1] = 32'h204; addr_pool[2] = 32'h100; addr_pool[3] = 32'h180;
        f5_pool[0] = 5'd1;  f5_pool[1] = 5'd0;  f5_pool[2] = 5'd4;  f5_pool[3] = 5'd12; f5_pool[4] = 5'd8;
        f5_pool[5] = 5'd16; f5_pool[6] = 5'd20; f5_pool[7] = 5'd24; f5_pool[8] = 5'd28; f5_pool[9] = 5'd31;

        rst = 1'b1;
        amo_valid = 1'b0; amo_funct5 = 5'd0; address = 32'd0; rs2_value = 32'd0;
        lr_valid = 1'b0; sc_valid = 1'b0; store_valid = 1'b0; trap = 1'b0; stall_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_stall", {31'd0, o_stall}, 32'd0);
        checkOutput("rst_own", {31'd0, mem_if.o_mem_own}, 32'd0);
        checkOutput("rst_we", {28'd0, mem_if.o_mem_byte_we}, 32'd0);
        checkOutput("rst_result_valid", {31'd0, o_result_valid}, 32'd0);
        checkOutput("rst_res_valid", {31'd0, o_reservation_valid}, 32'd0);
        checkOutput("rst_result", o_result, 32'd0);
        checkOutput("rst_mem_addr", mem_if.o_mem_addr, 32'd0);
        checkOutput("rst_mem_wdata", mem_if.o_mem_wdata, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 256; i++) preload(i[7:0], $urandom);

        // AMOADD 5 + 7
        preload(8'h40, 32'd5);
        applyStimulus(5'd0, 32'h100, 32'd7, 0);
        checkOutput("add_mem", mem[8'h40], 32'd12);

        // Signed vs unsigned minimum on all-ones
        preload(8'h50, 32'hFFFF_FFFF);
        applyStimulus(5'd16, 32'h140, 32'd1, 0);
        checkOutput("min_mem", mem[8'h50], 32'hFFFF_FFFF);
        applyStimulus(5'd24, 32'h140, 32'd1, 0);
        checkOutput("minu_mem", mem[8'h50], 32'd1);

        // Back-to-back swaps
        preload(8'h60, 32'd0);
        wbefore = writes_seen;
        applyStimulus(5'd1, 32'h180, 32'hA, 0);
        applyStimulus(5'd1, 32'h180, 32'hB, 0);
        checkOutput("swap_mem", mem[8'h60], 32'hB);
        checkOutput("swap_writes", writes_seen - wbefore, 32'd2);

        // DONE held by external stall
        preload(8'h70, 32'h1234);
        wbefore = writes_seen;
        applyStimulus(5'd4, 32'h1C0, 32'hFF, 2);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("hold_writes", writes_seen - wbefore, 32'd1);

        // Reservation sequence
        applyPipe(1'b1, 1'b0, 1'b0, 1'b0, 32'h200);
        checkOutput("lr_addr", {2'b00, o_reservation_addr}, 32'h80);
        applyPipe(1'b0, 1'b0, 1'b1, 1'b0, 32'h204);
        applyPipe(1'b0, 1'b0, 1'b1, 1'b0, 32'h200);
        applyPipe(1'b1, 1'b0, 1'b0, 1'b0, 32'h200);
        applyPipe(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        applyPipe(1'b1, 1'b0, 1'b0, 1'b0, 32'h200);
        applyPipe(1'b0, 1'b1, 1'b0, 1'b0, 32'h200);
        applyPipe(1'b1, 1'b0, 1'b0, 1'b1, 32'h200);

        // Reset while in READ
        applyPipe(1'b1, 1'b0, 1'b0, 1'b0, 32'h300);
        amo_valid = 1'b1; amo_funct5 = 5'd0; address = 32'h2C0; rs2_value = 32'd3;
        @(posedge clk);
        #1;
        rst = 1'b1;
        amo_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        res_v = 1'b0;
        checkOutput("rstmid_stall", {31'd0, o_stall}, 32'd0);
        checkOutput("rstmid_we", {28'd0, mem_if.o_mem_byte_we}, 32'd0);
        checkOutput("rstmid_res_valid", {31'd0, o_reservation_valid}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstmid_mem", mem[8'hB0], ref_mem[8'hB0]);

        // Randomized traffic
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 8);
            a = ($urandom_range(0, 1) == 0) ? addr_pool[$urandom_range(0, 3)] : {22'd0, $urandom_range(0, 255), 2'b00};
            case (op)
                0, 1, 2, 3: applyStimulus(f5_pool[$urandom_range(0, 9)], a, $urandom, $urandom_range(0, 2));
                4: applyPipe(1'b1, 1'b0, 1'b0, 1'b0, a);
                5: applyPipe(1'b0, 1'b1, 1'b0, 1'b0, a);
                6: applyPipe(1'b0, 1'b0, 1'b1, 1'b0, a);
                7: applyPipe(1'b0, 1'b0, 1'b0, 1'b1, a);
                default: applyPipe(1'b1, 1'b0, 1'b0, 1'b1, a);
            endcase
        end

        repeat (5) @(posedge clk);
        #1;
        checkOutput("results_left", exp_res_q.size(), 32'd0);
        checkOutput("writes_left", exp_wr_q.size(), 32'd0);
        checkOutput("write_count", writes_seen, writes_expected);
        mism = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
        checkOutput("final_mem_words_wrong", mism, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/ma_amo_unit.md
Name: ma_amo_unit

Overview:
- Memory-access-stage atomic sequencer, directly downstream of execute; consumes the registered execute-to-MA bundle.
- Performs the read-modify-write for RV32A AMO instructions on the single-ported data memory, stalling the pipeline while busy.
- Owns the LR/SC reservation register that execute reads for SC success evaluation.

Parameters:
XLEN, 32, datapath width; only word (.W) AMOs are supported.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_amo_valid  in  1  AMO (not LR/SC) present in MA; upstream already gated with ~exception
i_amo_funct5  in  5  instruction[31:27]
i_address  in  XLEN  word-aligned AMO/LR/SC/store address
i_rs2_value  in  XLEN  AMO operand
i_lr_valid  in  1  LR.W in MA
i_sc_valid  in  1  SC.W in MA
i_store_valid  in  1  plain store in MA
i_trap  in  1  trap taken this cycle
i_stall  in  1  external pipeline stall, excluding o_stall
i_mem_rdata  in  XLEN  memory read data, valid one cycle after address
o_mem_addr  out  XLEN  memory address while busy
o_mem_wdata  out  XLEN  write data
o_mem_byte_we  out  4  byte write enables
o_mem_own  out  1  this unit drives the memory port
o_stall  out  1  hold pipeline
o_result_valid  out  1  o_result valid for rd writeback
o_result  out  XLEN  original memory word
o_reservation_valid  out  1  reservation held
o_reservation_addr  out  XLEN-2  reserved word address (address[XLEN-1:2])

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0: o_stall, o_mem_own, o_mem_byte_we, o_result_valid, o_reservation_valid.
  - o_result, o_mem_addr, o_mem_wdata are 0 at reset.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - On i_amo_valid: latch address, funct5, rs2; drive o_mem_addr=i_address, o_mem_own=1, byte_we=0, o_stall=1; next state READ.
  - Otherwise o_stall=0.
- READ (one cycle after address issued):
  - Capture i_mem_rdata as old value.
  - Compute new = f(old, rs2).
  - Assert o_stall=1, o_mem_own=1.
  - next state WRITE.
- WRITE:
  - Drive o_mem_addr=latched address, o_mem_wdata=new, byte_we=4'hF, o_mem_own=1, o_stall=1.
  - next state DONE.
- DONE:
  - o_stall=0, o_result_valid=1, o_result=old, o_mem_own=0.
  - If i_stall, remain in DONE with outputs held; else go to IDLE.
  - i_amo_valid is ignored in DONE (the same instruction is still present).
- Latency: o_stall is high for exactly 3 cycles (IDLE-start, READ, WRITE) absent i_stall; result is visible in cycle 4. Back-to-back AMOs start the cycle after DONE exits.
- funct5 decode:
  - 00001 SWAP: rs2
  - 00000 ADD: old+rs2, mod 2^XLEN
  - 00100 XOR
  - 01100 AND
  - 01000 OR
  - 10000 MIN: signed
  - 10100 MAX: signed
  - 11000 MINU: unsigned
  - 11100 MAXU: unsigned
  - Any other value: write back old unchanged (no memory change); result is still old.
- Reservation updates, evaluated each cycle with ~i_stall & ~o_stall, priority order:
  1. i_trap or i_rst → clear.
  2. i_sc_valid → clear, regardless of success.
  3. i_lr_valid → set, addr=i_address[XLEN-1:2] (a new LR overwrites).
  4. i_store_valid, or an AMO in WRITE, whose word address equals o_reservation_addr → clear. The AMO case clears regardless of stall.
- Simultaneous events:
  - LR and trap in the same cycle → cleared.
  - Reset mid-operation (READ/WRITE) → IDLE next cycle, no write issued after the reset edge, reservation cleared.
- Word-only: address[1:0] is ignored (misalignment is trapped upstream).

Test Plan:
- mem[0x100]=5, AMOADD rs2=7 at 0x100 → o_stall high 3 cycles; WRITE cycle drives wdata=12, byte_we=F; DONE o_result=5; mem=12.
- mem=0xFFFFFFFF, AMOMIN rs2=1 → new=0xFFFFFFFF, result 0xFFFFFFFF. Then AMOMINU rs2=1 → new=1.
- Back-to-back AMOSWAP rs2=0xA then AMOSWAP rs2=0xB at the same address, initial 0 → results 0 then 0xA; final mem 0xB; exactly 2 writes.
- i_stall held 2 cycles in DONE → o_result_valid stays 1 for 3 cycles, no new read issued, single write.
- LR 0x200 → reservation_valid=1, addr=0x80. Store to 0x204 leaves it set. Store to 0x200 clears it. LR again then i_trap clears it. LR then SC clears it.
- i_rst asserted in READ → next cycle IDLE, byte_we=0, o_stall=0, reservation_valid=0; memory unchanged.
